// File: rtl/pipe_ctrl_if.sv
// Stall/mul-div handshake bundle between the pipeline stages and pipe_ctrl.
// The pipeline side is the master; the stall controller is the slave.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        md_start;
  logic        md_is_div;
  logic        abort;
  logic [5:0]  stall;
  logic        md_busy;
  logic        md_ready;
  logic [15:0] stall_cnt;

  modport master (
    output stallreq_id, md_start, md_is_div, abort,
    input  stall, md_busy, md_ready, stall_cnt
  );

  modport slave (
    input  stallreq_id, md_start, md_is_div, abort,
    output stall, md_busy, md_ready, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: load-use holds plus a multi-cycle mul/div sequencer
// (IDLE -> MD_BUSY -> MD_DONE) and a saturating count of PC-stall cycles.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 4
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  // Stages frozen by a load-use request: PC, IF, ID.
  localparam logic [5:0] ID_MASK  = 6'b000111;
  // Stages frozen by a mul/div: PC, IF, ID, EX.
  localparam logic [5:0] MD_MASK  = 6'b001111;

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic        md_busy_reg;
  logic        md_ready_reg;
  logic [15:0] stall_cnt_reg;

  logic        md_stall;
  logic        id_stall;
  logic [5:0]  stall_next;

  // Combinational so EX freezes in the issue cycle; abort and reset cancel it at once.
  assign md_stall = !rst && !bus.abort &&
                    (((state_reg == IDLE) && bus.md_start) || (state_reg == MD_BUSY));
  assign id_stall = !rst && bus.stallreq_id;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_stall
      assign stall_next[gi] = (md_stall && MD_MASK[gi]) || (id_stall && ID_MASK[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      md_busy_reg  <= 1'b0;
      md_ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          md_ready_reg <= 1'b0;
          if (bus.md_start) begin
            state_reg   <= MD_BUSY;
            cnt_reg     <= bus.md_is_div ? DIV_LOAD : MUL_LOAD;
            md_busy_reg <= 1'b1;
          end else begin
            md_busy_reg <= 1'b0;
          end
        end
        MD_BUSY: begin
          md_busy_reg <= 1'b1;
          if (cnt_reg == '0) begin
            state_reg    <= MD_DONE;
            md_ready_reg <= 1'b1;
          end else begin
            cnt_reg      <= cnt_reg - 6'd1;
            md_ready_reg <= 1'b0;
          end
        end
        MD_DONE: begin
          state_reg    <= IDLE;
          md_busy_reg  <= 1'b0;
          md_ready_reg <= 1'b0;
        end
        default: begin
          state_reg    <= IDLE;
          cnt_reg      <= '0;
          md_busy_reg  <= 1'b0;
          md_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_next[0] && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  // Registered status is masked during reset so it reads idle immediately.
  assign bus.stall     = stall_next;
  assign bus.md_busy   = md_busy_reg && !rst;
  assign bus.md_ready  = md_ready_reg && !rst;
  assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameters: DIV_CYCLES, default 32, number of MD_BUSY cycles for a divide; MUL_CYCLES, default 4, number of MD_BUSY cycles for a multiply.
REQ-002 SHALL have port clk  input  1  clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port stallreq_id  input  1  load-use hazard request from ID.
REQ-005 SHALL have port md_start  input  1  one-cycle pulse from EX issuing a multi-cycle mul/div.
REQ-006 SHALL have port md_is_div  input  1  qualifies md_start: 1 = divide, 0 = multiply.
REQ-007 SHALL have port abort  input  1  cancels an in-flight mul/div sequence.
REQ-008 SHALL have port stall  output  6  stage stop bus, bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB; 1 = Stop.
REQ-009 SHALL have port md_busy  output  1  high while the mul/div sequencer is not IDLE.
REQ-010 SHALL have port md_ready  output  1  one-cycle pulse; EX captures the mul/div result this cycle.
REQ-011 SHALL have port stall_cnt  output  16  count of cycles with stall[0]=1, saturating.

Function
REQ-012 SHALL implement the FSM states IDLE, MD_BUSY and MD_DONE, plus a 6-bit down-counter cnt.
REQ-013 In IDLE with md_start=1, the FSM SHALL go to MD_BUSY next cycle and load cnt with (md_is_div ? DIV_CYCLES : MUL_CYCLES) - 1.
REQ-014 In MD_BUSY, cnt SHALL decrement each cycle; when cnt==0 the FSM SHALL go to MD_DONE next cycle.
- MD_BUSY lasts exactly DIV_CYCLES or MUL_CYCLES cycles.
REQ-015 MD_DONE SHALL last one cycle, assert md_ready=1, and then return to IDLE.
REQ-016 md_start SHALL be ignored in MD_BUSY and MD_DONE; no queuing.
REQ-017 md_stall = (state==IDLE & md_start) | (state==MD_BUSY); it is combinational, so EX holds in the issue cycle itself.
REQ-018 stall SHALL be 6'b001111 when md_stall=1.
- This holds PC, IF, ID and EX, and drains MEM and WB.
REQ-019 When md_stall=0 and stallreq_id=1, stall SHALL be 6'b000111.
- This holds PC, IF and ID, and inserts a bubble into EX.
REQ-020 When md_stall=0 and stallreq_id=0, stall SHALL be 6'b000000.
REQ-021 md_stall SHALL take priority over stallreq_id when both are active.
REQ-022 In MD_DONE, stall SHALL be 000000 or 000111 according to stallreq_id alone.
REQ-023 md_busy SHALL be 1 in MD_BUSY and MD_DONE, and 0 in IDLE.
REQ-024 abort=1 in any state SHALL force IDLE next cycle without a md_ready pulse.
- While abort=1, md_stall is forced to 0 that cycle, including when md_start=1 in the same cycle.
REQ-025 stall_cnt SHALL increment by 1 on each edge where stall[0]=1, and SHALL hold at 16'hFFFF.
REQ-026 All outputs except stall and stall_cnt SHALL be registered functions of state.
- stall is combinational from state, md_start, abort and stallreq_id.

Reset
REQ-027 When rst=1, state SHALL become IDLE, cnt 0 and stall_cnt 0, overriding all inputs including md_start and abort.
REQ-028 While rst=1, stall SHALL read 6'b000000 and md_busy and md_ready SHALL read 0.
REQ-029 rst asserted mid-MD_BUSY SHALL discard the sequence; no md_ready pulse follows.

Verification
REQ-030 Divide issue: md_start=1 with md_is_div=1 at cycle 0 -> stall=001111 in cycles 0..32, md_ready=1 in cycle 33 only, stall=000000 in cycle 33, stall_cnt=33.
REQ-031 Multiply issue: md_start=1 with md_is_div=0 -> stall=001111 for 5 cycles, then md_ready pulse, md_busy low in cycle 6.
REQ-032 Load-use: stallreq_id=1 for 1 cycle in IDLE -> stall=000111 that cycle only, stall_cnt +1.
REQ-033 Overlap: stallreq_id=1 throughout a multiply -> stall=001111 for cycles 0..4, 000111 in the MD_DONE cycle.
REQ-034 Abort and reset: abort at MD_BUSY cycle 10 -> IDLE next cycle, no md_ready; rst at divide cycle 5 -> IDLE, stall_cnt=0, no md_ready.
REQ-035 Saturation and ignore: preload stall_cnt to 16'hFFFE with 3 stall cycles -> reads FFFF; md_start during MD_BUSY -> no change in sequence length.
